// File: rtl/vr_buffer_pkg.sv
// Shared constants, width helper and types for the multichannel ejector buffer.
package vr_buffer_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_DEPTH        = 4;

  // A one-channel buffer still carries a 1-bit channel tag.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_CH_ID_W = clog2_min1(DEF_NUM_CHANNELS);
  localparam int DEF_CNT_W   = $clog2(DEF_DEPTH + 1);

  typedef logic [DEF_CH_ID_W-1:0] ch_id_t;
  typedef logic [DEF_CNT_W-1:0]   cnt_t;

  typedef enum logic {ARB_OPEN, ARB_LOCKED} arb_state_e;

endpackage

// File: rtl/vr_sync_fifo.sv
// Single-clock FIFO with occupancy count; push/pop are ignored when full/empty.
module vr_sync_fifo #(
  parameter int  DataWidth = 32,
  parameter int  Depth     = 4,
  localparam int PtrW      = $clog2(Depth),
  localparam int CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_push,
  input  logic                 i_pop,
  input  logic [DataWidth-1:0] i_wdata,
  output logic [DataWidth-1:0] o_rdata,
  output logic                 o_empty,
  output logic                 o_full,
  output logic [CntWidth-1:0]  o_count
);

  logic [Depth-1:0][DataWidth-1:0] r_mem;
  logic [PtrW-1:0]                 r_wptr, r_rptr;
  logic [CntWidth-1:0]             r_count;
  logic                            w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntWidth'(Depth));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntWidth'(1);
        2'b01:   r_count <= r_count - CntWidth'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vr_multichannel_ejector_buffer.sv
// Per-channel FIFOs merged onto one tagged valid/ready output by round-robin;
// a stalled grant is held so the presented word never changes under backpressure.
module vr_multichannel_ejector_buffer
  import vr_buffer_pkg::*;
#(
  parameter int  DataWidth   = DEF_DATA_WIDTH,
  parameter int  NumChannels = DEF_NUM_CHANNELS,
  parameter int  Depth       = DEF_DEPTH,
  localparam int ChIdWidth   = clog2_min1(NumChannels),
  localparam int CntWidth    = $clog2(Depth + 1)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NumChannels-1:0]          i_in_valid,
  output logic [NumChannels-1:0]          o_in_ready,
  input  logic [NumChannels*DataWidth-1:0] i_in_data,
  output logic                            o_out_valid,
  input  logic                            i_out_ready,
  output logic [DataWidth-1:0]            o_out_data,
  output logic [ChIdWidth-1:0]            o_out_ch,
  output logic [NumChannels*CntWidth-1:0] o_occupancy
);

  logic [NumChannels-1:0]                w_empty, w_full, w_push, w_pop;
  logic [NumChannels-1:0][DataWidth-1:0] w_rdata;
  logic [NumChannels-1:0][CntWidth-1:0]  w_count;
  logic [ChIdWidth-1:0]                  r_rr_ptr, r_held_g, w_rr_g, w_g;
  arb_state_e                            r_state, w_state_nxt;
  logic                                  w_fire;

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
    assign o_in_ready[gi] = ~i_rst & ~w_full[gi];
    assign w_push[gi]     = i_in_valid[gi] & o_in_ready[gi];
    assign w_pop[gi]      = w_fire & (w_g == ChIdWidth'(gi));
    assign o_occupancy[gi*CntWidth +: CntWidth] = w_count[gi];

    vr_sync_fifo #(.DataWidth(DataWidth), .Depth(Depth)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push[gi]),
      .i_pop   (w_pop[gi]),
      .i_wdata (i_in_data[gi*DataWidth +: DataWidth]),
      .o_rdata (w_rdata[gi]),
      .o_empty (w_empty[gi]),
      .o_full  (w_full[gi]),
      .o_count (w_count[gi])
    );
  end

  // Descending scan so the channel nearest rr_ptr is the last one written.
  always_comb begin
    int idx;
    idx    = 0;
    w_rr_g = '0;
    for (int k = NumChannels - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NumChannels) idx = idx - NumChannels;
      if (!w_empty[idx]) w_rr_g = ChIdWidth'(idx);
    end
  end

  assign w_g         = (r_state == ARB_LOCKED) ? r_held_g : w_rr_g;
  assign o_out_valid = |(~w_empty);
  assign w_fire      = o_out_valid & i_out_ready;
  assign o_out_data  = o_out_valid ? w_rdata[w_g] : '0;
  assign o_out_ch    = o_out_valid ? w_g : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_OPEN:   if (o_out_valid && !i_out_ready) w_state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (i_out_ready) w_state_nxt = ARB_OPEN;
      default:    w_state_nxt = ARB_OPEN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ARB_OPEN;
      r_held_g <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARB_OPEN && w_state_nxt == ARB_LOCKED) r_held_g <= w_g;
      if (w_fire)
        r_rr_ptr <= (w_g == ChIdWidth'(NumChannels - 1)) ? '0 : w_g + ChIdWidth'(1);
    end
  end

endmodule

// File: tb/tb_vr_multichannel_ejector_buffer.sv
// Directed bench: stimulus queues expected (channel, data) words, a negedge
// monitor pops and compares them on every output handshake.
module tb_vr_multichannel_ejector_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   in_valid = '0;
  logic [127:0] in_data  = '0;
  logic         out_ready = 1'b0;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic [11:0]  occ;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  vr_multichannel_ejector_buffer #(.DataWidth(32), .NumChannels(4), .Depth(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_ch    (out_ch),
    .o_occupancy (occ)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (occ[i*3 +: 3] > 3'd4) begin
          errors++;
          $display("FAIL occupancy_bound ch%0d: got %0d, limit 4", i, occ[i*3 +: 3]);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (occ[out_ch*3 +: 3] == 3'd0) begin
          errors++;
          $display("FAIL pop_while_empty: ch%0d has occupancy 0", out_ch);
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got ch%0d data 0x%0h, expected no word", out_ch, out_data);
        end else begin
          e = q.pop_front();
          if (out_ch !== e.ch || out_data !== e.data) begin
            errors++;
            $display("FAIL output_word: got ch%0d data 0x%0h, expected ch%0d data 0x%0h",
                     out_ch, out_data, e.ch, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_word(input int ch, input logic [31:0] d);
    in_data[ch*32 +: 32] = d;
  endtask

  task automatic expect_word(input logic [1:0] ch, input logic [31:0] d);
    q.push_back('{ch: ch, data: d});
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words still expected, required 0", nm, q.size());
      q.delete();
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit accepted;

    // 1. reset release
    rst = 1'b1; in_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_in_ready", in_ready, 4'b0000);
      chk("rst_out_valid", out_valid, 1'b0);
    end
    rst = 1'b0; in_valid = '0;
    tick();
    chk("post_rst_in_ready", in_ready, 4'b1111);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_occ", occ, 12'h000);
    chk("post_rst_out_data", out_data, 32'h0);
    chk("post_rst_out_ch", out_ch, 2'd0);

    // 2. fill ch2 to full, fifth word held upstream
    out_ready = 1'b0;
    in_valid  = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      set_word(2, 32'hA0 + k);
      expect_word(2'd2, 32'hA0 + k);
      tick();
    end
    set_word(2, 32'hA4);
    expect_word(2'd2, 32'hA4);
    tick(); tick();
    chk("full_occ2", occ[8:6], 3'd4);
    chk("full_in_ready2", in_ready[2], 1'b0);
    out_ready = 1'b1;
    accepted  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready[2]) begin
        tick();
        accepted = 1'b1;
        break;
      end
      tick();
    end
    in_valid = '0;
    chk("a4_accepted", accepted, 1'b1);
    wait_drain("fill");

    // 3. round-robin fairness
    reset_dut();
    for (int j = 0; j < 2; j++) begin
      in_valid = 4'b1111;
      for (int k = 0; k < 4; k++) set_word(k, k * 16 + j);
      tick();
    end
    in_valid = '0;
    chk("rr_preload_occ", occ, 12'h492);
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 4; k++) expect_word(2'(k), k * 16 + j);
    out_ready = 1'b1;
    wait_drain("rr");

    // 4. lock stability under backpressure
    reset_dut();
    in_valid = 4'b1000; set_word(3, 32'h3C);
    tick();
    in_valid = '0;
    tick();
    in_valid = 4'b0001; set_word(0, 32'h0D);
    tick();
    in_valid = '0;
    for (int i = 0; i < 3; i++) begin
      chk("lock_out_ch", out_ch, 2'd3);
      chk("lock_out_data", out_data, 32'h3C);
      tick();
    end
    expect_word(2'd3, 32'h3C);
    expect_word(2'd0, 32'h0D);
    out_ready = 1'b1;
    wait_drain("lock");

    // 5. simultaneous push and pop on ch1
    reset_dut();
    in_valid = 4'b0010;
    set_word(1, 32'h50); tick();
    set_word(1, 32'h51); tick();
    chk("pp_pre_occ1", occ[5:3], 3'd2);
    for (int k = 0; k < 12; k++) expect_word(2'd1, 32'h50 + k);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      set_word(1, 32'h52 + k);
      tick();
      chk("pp_occ1", occ[5:3], 3'd2);
    end
    in_valid = '0;
    wait_drain("pushpop");

    // 6. reset mid-operation drops buffered words
    reset_dut();
    in_valid = 4'b0111;
    set_word(0, 32'h60); set_word(1, 32'h61); set_word(2, 32'h62);
    tick();
    in_valid = '0;
    chk("midrst_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_occ", occ, 12'h000);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    expect_word(2'd1, 32'h77);
    in_valid = 4'b0010; set_word(1, 32'h77);
    tick();
    in_valid = '0;
    wait_drain("midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
